// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus between the 3-stage pipeline and pipe_hazard_ctrl.
// master: pipeline side (drives DE/WB status and mem_ready, receives controls).
// slave : hazard controller (receives status, drives mem_req/stall/flush/forwarding).
// Status  : rs1_de, rs2_de, use_rs1, use_rs2, br_taken, rd_wb, reg_wr_wb,
//           rd_en_wb, wr_en_wb, wb_sel_wb, mem_ready
// Control : mem_req, stall, flush_if, wb_kill, fwd_a, fwd_b, timeout_err, stall_cnt
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_de;
  logic [4:0]       rs2_de;
  logic             use_rs1;
  logic             use_rs2;
  logic             br_taken;
  logic [4:0]       rd_wb;
  logic             reg_wr_wb;
  logic             rd_en_wb;
  logic             wr_en_wb;
  logic [1:0]       wb_sel_wb;
  logic             mem_ready;

  logic             mem_req;
  logic             stall;
  logic             flush_if;
  logic             wb_kill;
  logic             fwd_a;
  logic             fwd_b;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_de, rs2_de, use_rs1, use_rs2, br_taken, rd_wb,
           reg_wr_wb, rd_en_wb, wr_en_wb, wb_sel_wb, mem_ready,
    input  mem_req, stall, flush_if, wb_kill, fwd_a, fwd_b,
           timeout_err, stall_cnt
  );

  modport slave (
    input  rs1_de, rs2_de, use_rs1, use_rs2, br_taken, rd_wb,
           reg_wr_wb, rd_en_wb, wr_en_wb, wb_sel_wb, mem_ready,
    output mem_req, stall, flush_if, wb_kill, fwd_a, fwd_b,
           timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the IF / DE / WB core.
// Ports: clk, reset (async, active-high), bus (pipe_hazard_ctrl_if.slave):
//   WB memory access handshake with wait-state timeout, stall generation,
//   branch flush of IF, DE operand forwarding from WB, saturating stall counter.
// stall, flush_if, mem_req, wb_kill, timeout_err and fwd_* are combinational;
// stall_cnt is registered.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned       WAIT_W    = 16;
  localparam int unsigned       FL_W      = 2;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [FL_W-1:0]   FL_INIT   = FL_W'(BR_PENALTY - 1);
  localparam bit                USE_FLUSH = (BR_PENALTY > 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              live_q;

  logic mem_acc, mem_miss, timeout_fire;
  logic stall_c, flush_c, kill_c;
  logic unused_wb_sel;

  assign unused_wb_sel = ^bus.wb_sel_wb;

  // Outputs stay quiet until one clock edge after reset release.
  assign mem_acc      = bus.rd_en_wb | bus.wr_en_wb;
  assign mem_miss     = live_q & mem_acc & ~bus.mem_ready;
  assign timeout_fire = (state_q == MEM_WAIT) & mem_miss & (wait_cnt_q == WAIT_LAST);

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    kill_c     = 1'b0;
    if (live_q) begin
      case (state_q)
        RUN: begin
          if (mem_miss) begin
            stall_c    = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (bus.br_taken) begin
            flush_c = 1'b1;
            if (USE_FLUSH) begin
              state_d  = FLUSH;
              fl_cnt_d = FL_INIT;
            end
          end
        end
        MEM_WAIT: begin
          if (timeout_fire) begin
            // Abort: kill the WB write; DE replays any branch seen now.
            kill_c     = 1'b1;
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (mem_miss) begin
            stall_c    = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            if (bus.br_taken) begin
              flush_c = 1'b1;
              if (USE_FLUSH) begin
                state_d  = FLUSH;
                fl_cnt_d = FL_INIT;
              end
            end
          end
        end
        FLUSH: begin
          if (mem_miss) begin
            // Redirect already happened; the remaining flush cycles are dropped.
            stall_c    = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
            fl_cnt_d   = '0;
          end else begin
            flush_c = 1'b1;
            if (fl_cnt_q <= FL_W'(1)) begin
              state_d  = RUN;
              fl_cnt_d = '0;
            end else begin
              fl_cnt_d = fl_cnt_q - FL_W'(1);
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, counters and the reset-release qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      fl_cnt_q    <= '0;
      stall_cnt_q <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      live_q     <= 1'b1;
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush_if    = flush_c;
  assign bus.wb_kill     = kill_c;
  assign bus.timeout_err = kill_c;
  assign bus.mem_req     = live_q & mem_acc & ~timeout_fire;
  assign bus.stall_cnt   = stall_cnt_q;

  // x0 is never forwarded; a killed WB write is never forwarded.
  assign bus.fwd_a = live_q & bus.use_rs1 & bus.reg_wr_wb & ~kill_c &
                     (bus.rd_wb != 5'd0) & (bus.rd_wb == bus.rs1_de);
  assign bus.fwd_b = live_q & bus.use_rs2 & bus.reg_wr_wb & ~kill_c &
                     (bus.rd_wb != 5'd0) & (bus.rd_wb == bus.rs2_de);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the access/flush rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned T_OUT = 4;
  localparam int unsigned PEN   = 2;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (T_OUT),
    .BR_PENALTY  (PEN),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.rs1_de    = 5'd0;
    bus.rs2_de    = 5'd0;
    bus.use_rs1   = 1'b0;
    bus.use_rs2   = 1'b0;
    bus.br_taken  = 1'b0;
    bus.rd_wb     = 5'd0;
    bus.reg_wr_wb = 1'b0;
    bus.rd_en_wb  = 1'b0;
    bus.wr_en_wb  = 1'b0;
    bus.wb_sel_wb = 2'b00;
    bus.mem_ready = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: age of the current waiting access, flush cycles still
  // owed, whether the core is past its first post-reset cycle, stall count.
  int m_age;
  int m_fl_left;
  bit m_live;
  int m_cnt;

  always @(negedge clk) begin : compare
    bit acc, miss, tmo, e_stall, e_flush, e_req, e_fa, e_fb;
    acc = 0; miss = 0; tmo = 0;
    e_stall = 0; e_flush = 0; e_req = 0; e_fa = 0; e_fb = 0;
    if (reset) begin
      m_live = 0; m_age = 0; m_fl_left = 0; m_cnt = 0;
    end else if (m_live) begin
      acc  = bus.rd_en_wb || bus.wr_en_wb;
      miss = acc && !bus.mem_ready;
      // The access is aborted on its MEM_TIMEOUT-th cycle without ready.
      tmo     = miss && (m_age + 1 == int'(T_OUT));
      e_stall = miss && !tmo;
      e_req   = acc && !tmo;
      if (e_stall) begin
        m_fl_left = 0;
      end else if (m_fl_left > 0) begin
        e_flush = 1;
        m_fl_left--;
      end else if (bus.br_taken && !tmo) begin
        e_flush   = 1;
        m_fl_left = int'(PEN) - 1;
      end
      e_fa = bus.use_rs1 && bus.reg_wr_wb && !tmo && bus.rd_wb != 0 && bus.rd_wb == bus.rs1_de;
      e_fb = bus.use_rs2 && bus.reg_wr_wb && !tmo && bus.rd_wb != 0 && bus.rd_wb == bus.rs2_de;
    end
    check("m_stall",   32'(bus.stall),       32'(e_stall));
    check("m_flush",   32'(bus.flush_if),    32'(e_flush));
    check("m_req",     32'(bus.mem_req),     32'(e_req));
    check("m_kill",    32'(bus.wb_kill),     32'(tmo));
    check("m_tmo",     32'(bus.timeout_err), 32'(tmo));
    check("m_fwd_a",   32'(bus.fwd_a),       32'(e_fa));
    check("m_fwd_b",   32'(bus.fwd_b),       32'(e_fb));
    check("m_cnt",     32'(bus.stall_cnt),   32'(m_cnt));
    if (!reset) begin
      if (m_live) begin
        m_age = e_stall ? m_age + 1 : 0;
        if (e_stall && m_cnt < CMAX) m_cnt++;
      end
      m_live = 1;
    end
  end

  initial begin
    total = 0; bad = 0;
    m_age = 0; m_fl_left = 0; m_live = 0; m_cnt = 0;
    reset = 1'b1;
    idle();
    bus.rd_en_wb = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_req",   32'(bus.mem_req), 0);
    check("rst_cnt",   32'(bus.stall_cnt), 0);

    // First cycle after release: still quiet despite a pending load.
    next(); reset = 1'b0;
    @(negedge clk);
    check("first_stall", 32'(bus.stall), 0);
    check("first_req",   32'(bus.mem_req), 0);
    next(); idle();

    // Zero-wait load with forwarding.
    next(); idle();
    bus.rd_en_wb = 1'b1; bus.mem_ready = 1'b1; bus.reg_wr_wb = 1'b1;
    bus.rd_wb = 5'd5; bus.rs1_de = 5'd5; bus.use_rs1 = 1'b1; bus.wb_sel_wb = 2'b10;
    @(negedge clk);
    check("zw_stall", 32'(bus.stall), 0);
    check("zw_req",   32'(bus.mem_req), 1);
    check("zw_fwd_a", 32'(bus.fwd_a), 1);
    next(); idle();
    @(negedge clk);
    check("zw_after_req", 32'(bus.mem_req), 0);

    // Three wait states.
    for (int i = 1; i <= 4; i++) begin
      next(); idle();
      bus.rd_en_wb = 1'b1; bus.mem_ready = (i == 4);
      @(negedge clk);
      check("w3_stall", 32'(bus.stall), (i < 4) ? 1 : 0);
    end
    next(); idle();
    @(negedge clk);
    check("w3_cnt",   32'(bus.stall_cnt), 3);
    check("w3_stall_after", 32'(bus.stall), 0);

    // Timeout.
    for (int i = 1; i <= 4; i++) begin
      next(); idle();
      bus.rd_en_wb = 1'b1; bus.reg_wr_wb = 1'b1;
      bus.rd_wb = 5'd5; bus.rs1_de = 5'd5; bus.use_rs1 = 1'b1;
      @(negedge clk);
      if (i < 4) begin
        check("to_stall", 32'(bus.stall), 1);
        check("to_fwd_a_wait", 32'(bus.fwd_a), 1);
      end else begin
        check("to_err",   32'(bus.timeout_err), 1);
        check("to_kill",  32'(bus.wb_kill), 1);
        check("to_stall_end", 32'(bus.stall), 0);
        check("to_req",   32'(bus.mem_req), 0);
        check("to_fwd_a", 32'(bus.fwd_a), 0);
      end
    end
    next(); idle();
    @(negedge clk);
    check("to_err_after", 32'(bus.timeout_err), 0);
    check("to_cnt", 32'(bus.stall_cnt), 6);

    // Branch penalty.
    next(); idle(); bus.br_taken = 1'b1;
    @(negedge clk); check("br_flush1", 32'(bus.flush_if), 1);
    next(); idle();
    @(negedge clk); check("br_flush2", 32'(bus.flush_if), 1);
    next();
    @(negedge clk); check("br_flush3", 32'(bus.flush_if), 0);

    // Branch behind a stalled store.
    for (int i = 1; i <= 3; i++) begin
      next(); idle();
      bus.wr_en_wb = 1'b1; bus.br_taken = 1'b1; bus.mem_ready = (i == 3);
      @(negedge clk);
      check("bs_flush", 32'(bus.flush_if), (i == 3) ? 1 : 0);
      check("bs_stall", 32'(bus.stall), (i < 3) ? 1 : 0);
    end
    next(); idle();
    @(negedge clk); check("bs_flush_tail", 32'(bus.flush_if), 1);
    next();
    @(negedge clk);
    check("bs_flush_end", 32'(bus.flush_if), 0);
    check("bs_cnt", 32'(bus.stall_cnt), 8);

    // Forwarding edges.
    next(); idle();
    bus.reg_wr_wb = 1'b1; bus.use_rs1 = 1'b1; bus.use_rs2 = 1'b1;
    @(negedge clk);
    check("fw_x0_a", 32'(bus.fwd_a), 0);
    check("fw_x0_b", 32'(bus.fwd_b), 0);
    next(); bus.rd_wb = 5'd7; bus.rs1_de = 5'd7; bus.rs2_de = 5'd7;
    @(negedge clk);
    check("fw_7_a", 32'(bus.fwd_a), 1);
    check("fw_7_b", 32'(bus.fwd_b), 1);
    next(); bus.use_rs2 = 1'b0;
    @(negedge clk);
    check("fw_nors2_a", 32'(bus.fwd_a), 1);
    check("fw_nors2_b", 32'(bus.fwd_b), 0);

    // Reset during MEM_WAIT.
    next(); idle(); bus.rd_en_wb = 1'b1;
    next();
    next();
    check("mr_pre_stall", 32'(bus.stall), 1);
    #1 reset = 1'b1;
    #1;
    check("mr_stall", 32'(bus.stall), 0);
    check("mr_req",   32'(bus.mem_req), 0);
    check("mr_cnt",   32'(bus.stall_cnt), 0);
    next(); idle(); reset = 1'b0;
    @(negedge clk);
    check("mr_rel_stall", 32'(bus.stall), 0);
    next();
    @(negedge clk);
    check("mr_live_stall", 32'(bus.stall), 0);
    check("mr_live_cnt",   32'(bus.stall_cnt), 0);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      next();
      bus.rs1_de    = 5'($urandom_range(0, 3));
      bus.rs2_de    = 5'($urandom_range(0, 3));
      bus.rd_wb     = 5'($urandom_range(0, 3));
      bus.use_rs1   = 1'($urandom_range(0, 1));
      bus.use_rs2   = 1'($urandom_range(0, 1));
      bus.reg_wr_wb = 1'($urandom_range(0, 1));
      bus.rd_en_wb  = ($urandom_range(0, 3) == 0);
      bus.wr_en_wb  = ($urandom_range(0, 3) == 0);
      bus.wb_sel_wb = 2'($urandom_range(0, 3));
      bus.mem_ready = ($urandom_range(0, 9) < 3);
      bus.br_taken  = ($urandom_range(0, 4) == 0);
    end
    next(); idle();
    @(negedge clk);
    check("sat_cnt", 32'(bus.stall_cnt), CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
